// File: rtl/multiplier_control.sv
// Sequencer for the n-bit shift-add multiplier: catches a rising start edge,
// loads AQ, then issues n add/shift or shift-only steps chosen by Q0.
module multiplier_control #(
  parameter int n = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     Q0,
  output logic                     load,
  output logic                     add_shift,
  output logic                     shift,
  output logic                     busy,
  output logic                     done,
  output logic                     ready,
  output logic [$clog2(n+1)-1:0]   count
);

  localparam int CW = $clog2(n+1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic          start_q;
  logic          ready_q, ready_d;
  logic [CW-1:0] count_q, count_d;
  logic          start_edge;

  // start only feeds next-state logic, so no output sees it combinationally
  assign start_edge = start & ~start_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      ready_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      ready_q <= ready_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    count_d   = count_q;
    load      = 1'b0;
    add_shift = 1'b0;
    shift     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (start_edge) begin
          state_d = LOAD;
          ready_d = 1'b0;
        end
      end
      LOAD: begin
        load    = 1'b1;
        busy    = 1'b1;
        ready_d = 1'b0;
        count_d = CW'(n);
        state_d = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        add_shift = Q0;
        shift     = ~Q0;
        if (count_q != '0) count_d = count_q - 1'b1;
        // last step: product is valid once DONE is entered
        if (count_q <= CW'(1)) begin
          state_d = DONE;
          ready_d = 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        count_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready = ready_q;
  assign count = count_q;

endmodule

// File: tb/tb_multiplier_control.sv
// Directed bench: n=4 controller driving a behavioural AQ register (M=6),
// plus an n=1 instance for the single-step boundary.
module tb_multiplier_control;

  localparam int N = 4;
  localparam logic [3:0] M = 4'd6;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       q0;
  logic       load, add_shift, shift, busy, done, ready;
  logic [2:0] count;

  logic       start1 = 1'b0;
  logic       q0_1 = 1'b1;
  logic       load1, add_shift1, shift1, busy1, done1, ready1;
  logic [0:0] count1;

  int vecs = 0;
  int errs = 0;

  multiplier_control #(.n(N)) dut (
    .clock(clock), .reset(reset), .start(start), .Q0(q0),
    .load(load), .add_shift(add_shift), .shift(shift),
    .busy(busy), .done(done), .ready(ready), .count(count)
  );

  multiplier_control #(.n(1)) u1 (
    .clock(clock), .reset(reset), .start(start1), .Q0(q0_1),
    .load(load1), .add_shift(add_shift1), .shift(shift1),
    .busy(busy1), .done(done1), .ready(ready1), .count(count1)
  );

  always #5 clock = ~clock;

  // AQ register model: A = aq[7:4], Q = aq[3:0]
  logic [7:0] aq = 8'h00;
  logic [3:0] qin = 4'h0;
  assign q0 = aq[0];

  always @(posedge clock) begin
    logic [4:0] s;
    s = {1'b0, aq[7:4]} + {1'b0, M};
    if (load)           aq <= {4'h0, qin};
    else if (add_shift) aq <= {s, aq[3:1]};
    else if (shift)     aq <= {1'b0, aq[7:1]};
  end

  int n_add = 0, n_shift = 0, n_load = 0, n_done = 0;
  always @(posedge clock) begin
    n_add   <= n_add + int'(add_shift);
    n_shift <= n_shift + int'(shift);
    n_load  <= n_load + int'(load);
    n_done  <= n_done + int'(done);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int b_add, b_shift, b_load, b_done;
  task automatic snap();
    b_add = n_add; b_shift = n_shift; b_load = n_load; b_done = n_done;
  endtask

  logic [3:0] pat;

  initial begin
    // reset state
    #1;
    chk("rst_outs", 32'({load, add_shift, shift, busy, done, ready}), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_outs_n1", 32'({load1, add_shift1, shift1, busy1, done1, ready1}), 0);
    step(); step();
    reset = 1'b0;
    step(); step();
    chk("idle_outs", 32'({load, add_shift, shift, busy, done, ready}), 0);
    chk("idle_count", 32'(count), 0);

    // nominal: Qin=0xE, M=6, start then held for 20 cycles
    qin = 4'hE; pat = 4'b1110;
    snap();
    start = 1'b1;
    step();
    chk("ld_load", 32'(load), 1);
    chk("ld_busy", 32'(busy), 1);
    chk("ld_ready", 32'(ready), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("run_count", 32'(count), 32'(4 - i));
      chk("run_busy", 32'(busy), 1);
      chk("run_add", 32'(add_shift), 32'(pat[i]));
      chk("run_shift", 32'(shift), 32'(!pat[i]));
      chk("run_load", 32'(load), 0);
    end
    step();
    chk("done_pulse", 32'(done), 1);
    chk("done_ready", 32'(ready), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_count", 32'(count), 0);
    step();
    chk("post_done", 32'(done), 0);
    chk("post_ready", 32'(ready), 1);
    chk("nom_aq", 32'(aq), 32'h54);
    chk("nom_adds", 32'(n_add - b_add), 3);
    chk("nom_shifts", 32'(n_shift - b_shift), 1);
    chk("nom_loads", 32'(n_load - b_load), 1);
    chk("nom_dones", 32'(n_done - b_done), 1);
    repeat (13) step();
    chk("held_loads", 32'(n_load - b_load), 1);
    chk("held_busy", 32'(busy), 0);
    chk("held_ready", 32'(ready), 1);

    // release, re-press with zero operand
    start = 1'b0;
    step();
    qin = 4'h0;
    snap();
    start = 1'b1;
    step();
    chk("rp_load", 32'(load), 1);
    chk("rp_ready_drop", 32'(ready), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("zero_shift", 32'(shift), 1);
      chk("zero_add", 32'(add_shift), 0);
    end
    step();
    chk("zero_done", 32'(done), 1);
    step();
    chk("zero_aq", 32'(aq), 0);
    chk("zero_ready", 32'(ready), 1);
    chk("zero_adds", 32'(n_add - b_add), 0);
    chk("zero_shifts", 32'(n_shift - b_shift), 4);

    // start glitch in RUN, and start rising as DONE is entered
    start = 1'b0;
    step();
    qin = 4'hE;
    snap();
    start = 1'b1;
    step();
    chk("gl_load", 32'(load), 1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("gl_count", 32'(count), 32'(4 - i));
      if (i == 1) start = 1'b1;
      if (i == 2) start = 1'b0;
      if (i == 3) start = 1'b1;
    end
    step();
    chk("gl_done", 32'(done), 1);
    step(); step(); step();
    chk("gl_loads", 32'(n_load - b_load), 1);
    chk("gl_steps", 32'((n_add - b_add) + (n_shift - b_shift)), 4);
    chk("gl_dones", 32'(n_done - b_done), 1);
    chk("gl_busy", 32'(busy), 0);
    chk("gl_aq", 32'(aq), 32'h54);

    // asynchronous reset at RUN step 3
    start = 1'b0;
    step();
    snap();
    start = 1'b1;
    step(); step(); step(); step();
    chk("rr_count", 32'(count), 2);
    chk("rr_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("rr_outs", 32'({load, add_shift, shift, busy, done, ready}), 0);
    chk("rr_count0", 32'(count), 0);
    start = 1'b0;
    step();
    reset = 1'b0;
    step(); step();
    chk("rr_nodone", 32'(n_done - b_done), 0);
    chk("rr_idle", 32'(busy), 0);

    // subsequent start works normally
    snap();
    start = 1'b1;
    step();
    chk("after_load", 32'(load), 1);
    repeat (4) step();
    step();
    chk("after_done", 32'(done), 1);
    step();
    chk("after_aq", 32'(aq), 32'h54);
    chk("after_ready", 32'(ready), 1);
    start = 1'b0;

    // n=1: single RUN cycle
    start1 = 1'b1;
    step();
    chk("n1_load", 32'(load1), 1);
    step();
    chk("n1_add", 32'(add_shift1), 1);
    chk("n1_count", 32'(count1), 1);
    chk("n1_busy", 32'(busy1), 1);
    step();
    chk("n1_done", 32'(done1), 1);
    chk("n1_ready", 32'(ready1), 1);
    chk("n1_count0", 32'(count1), 0);
    step();
    chk("n1_idle", 32'({done1, busy1}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
